// File: rtl/operand_latch_pipe.sv
// operand_latch_pipe: NCH-channel operand register with a ready/valid
// handshake on both sides. A main entry drives the outputs and a skid entry
// absorbs one extra beat when downstream stalls, so in_ready can come
// straight from a flop. Handshake rule: a beat moves on an edge only when
// valid and ready are both high in that cycle; valid never depends on ready.
module operand_latch_pipe #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_hold,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     beat_count
);

    localparam int DW = NCH * WIDTH;

    logic [DW-1:0]    r_main_data;
    logic [DW-1:0]    r_skid_data;
    logic [DW-1:0]    r_last;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_beat_count;

    logic [DW-1:0]    w_resolved;
    logic             w_accept;
    logic             w_deliver;
    logic             w_main_free;

    // The skid entry is only ever occupied while main is occupied, so a full
    // skid entry means the block is full.
    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && !r_skid_valid && !flush;
    assign w_deliver   = r_main_valid && out_ready;
    assign w_main_free = !r_main_valid || out_ready;

    assign out_data    = r_main_data;
    assign out_valid   = r_main_valid;
    assign occupancy   = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign beat_count  = r_beat_count;

    // Held channels reuse the operand from the previously accepted beat.
    always_comb begin
        w_resolved = in_data;
        for (int i = 0; i < NCH; i++) begin
            if (in_hold[i]) begin
                w_resolved[i*WIDTH +: WIDTH] = r_last[i*WIDTH +: WIDTH];
            end
        end
    end

    // Entry valid bits: flush empties both; otherwise shift skid into main.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_skid_valid <= w_accept;
            end else begin
                r_main_valid <= w_accept;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Entry data follows the valid bits; flush leaves the contents alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (!flush) begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    r_main_data <= r_skid_data;
                    if (w_accept) begin
                        r_skid_data <= w_resolved;
                    end
                end else if (w_accept) begin
                    r_main_data <= w_resolved;
                end
            end else if (w_accept) begin
                r_skid_data <= w_resolved;
            end
        end
    end

    // Remember the last accepted beat for the hold mask; flush keeps it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
        end else if (w_accept) begin
            r_last <= w_resolved;
        end
    end

    // Delivered-beat counter, wraps naturally; counts even during flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_count <= '0;
        end else if (w_deliver) begin
            r_beat_count <= r_beat_count + 1'b1;
        end
    end

endmodule

// File: doc/operand_latch_pipe.md
Name: operand_latch_pipe

Overview:
- Parametrised successor to the single-cycle A/B operand latch in the multicycle datapath.
- Registers NCH operand channels of WIDTH bits each, with a ready/valid handshake on both sides.
- A 2-entry skid buffer absorbs downstream stalls without losing data.
- Per-channel hold mask, synchronous flush, occupancy output and a wrapping beat counter.
- Sits between the register-file read ports and the ALU-operand stage; also usable anywhere stall/flush-able operand registers are needed.

Parameters:
- WIDTH, 32, bits per channel.
- NCH, 2, number of operand channels (2 = A/B).
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NCH*WIDTH  packed operands; channel i = bits [i*WIDTH +: WIDTH].
- in_hold  input  NCH  per-channel hold; sampled with the accepted beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- flush  input  1  synchronous discard of all buffered beats.
- out_data  output  NCH*WIDTH  head-entry operands.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head this cycle.
- occupancy  output  2  number of valid entries, 0..2.
- beat_count  output  CNT_W  count of beats delivered downstream; wraps modulo 2^CNT_W.

Behaviour:
- Storage:
  - main entry: data + valid, drives out_data/out_valid.
  - skid entry: data + valid.
  - last register: NCH*WIDTH, the last resolved beat.
- Reset (asynchronous, immediate on rst high, including mid-transfer): main_valid=0, skid_valid=0, all data registers=0, last=0, beat_count=0. Hence out_valid=0, out_data=0, occupancy=0, in_ready=1.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Accept: in_valid && in_ready && !flush.
- Deliver: out_valid && out_ready.
- Resolved beat: channel i = in_hold[i] ? last[i] : in_data[i]. On accept, last <= resolved. last is never cleared by flush.
- Next-state rules, evaluated at each edge with flush low:
  - main empty or delivering, skid valid: main <= skid; skid <= resolved if accept, else skid_valid=0.
  - main empty or delivering, skid empty: main <= resolved if accept, else main_valid=0.
  - main full and not delivering: if accept, skid <= resolved. Accept is impossible when skid is full because in_ready=0.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Latency: a beat accepted at edge k into an empty block shows on out_data with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Flush high at an edge:
  - main_valid=0 and skid_valid=0.
  - The input beat is not accepted and last is not updated.
  - A delivery asserted in that same cycle still counts: beat_count increments if out_valid && out_ready.
  - Data registers keep their contents.
- beat_count increments by 1 on every deliver edge; 2^CNT_W-1 wraps to 0.
- occupancy = main_valid + skid_valid.
- Simultaneous accept and deliver with occupancy 1 leaves occupancy 1.
- Simultaneous accept and deliver with occupancy 2 cannot occur, since in_ready=0.

Test Plan:
- Reset then single beat (defaults): after rst drop, in_data={B=0x2,A=0x1}, in_valid=1, out_ready=1 for one cycle -> next cycle out_valid=1, out_data={0x2,0x1}, then beat_count=1 and occupancy=0.
- Backpressure: out_ready=0, send beats 0x11, 0x22 -> occupancy=2, in_ready=0, third beat 0x33 stalls. Raise out_ready -> delivered in order 0x11, 0x22, 0x33 with no loss.
- Hold mask: send {B=5,A=7}, then {B=9,A=3} with in_hold=2'b10 -> second output {B=5,A=3}.
- Flush: occupancy=2 with out_ready=0, pulse flush with in_valid=1 and data 0x44 -> next cycle occupancy=0, out_valid=0, in_ready=1, and 0x44 is never delivered.
- Async reset mid-stream: assert rst between edges while occupancy=2 -> out_valid and out_data drop to 0 immediately, beat_count=0.
- Counter wrap with CNT_W=4: stream 17 beats at full throughput -> beat_count=1, with one output per cycle throughout.
